cla_serial_subtractor: RTL
==========================

// Module: cla_serial_subtractor
// PURPOSE
// - Digit-serial unsigned/two's-complement subtractor: D = A - B, 2 bits per clock.
// - Reuses one 2-bit carry-lookahead slice; B is inverted, carry-in seeded to 1.
// - Start/done handshake for the lab datapath; also provides compare flags (A<B, A==B).
// - Companion to the 2-bit CLA adder: the inverse operation, computed sequentially.
// PARAMETERS
// - WIDTH   8   operand/result width; must be even and >= 2
// - (local) NSLICE = WIDTH/2; CNT_W = $clog2(NSLICE)+1
// PORTS
// - clk     in   1      single clock; all state changes on its rising edge
// - rst     in   1      synchronous, active-high reset
// - start   in   1      request; sampled only while ready=1
// - a       in   WIDTH  minuend; captured on the accepted start edge
// - b       in   WIDTH  subtrahend; captured on the accepted start edge
// - ready   out  1      1 in IDLE only
// - busy    out  1      1 in RUN only
// - done    out  1      one-cycle pulse; results valid
// - diff    out  WIDTH  A - B, mod 2^WIDTH
// - borrow  out  1      1 iff A < B (unsigned); = ~carry-out of A + ~B + 1
// - ovf     out  1      signed overflow: (a[W-1]^b[W-1]) & (a[W-1]^diff[W-1])
// - zero    out  1      1 iff diff == 0
// BEHAVIOUR
// - One clock; reset is synchronous and active-high. Reset: state=IDLE, ready=1,
//   busy=0, done=0, diff=0, borrow=0, ovf=0, zero=0, internal carry=1, count=0.
// - FSM IDLE -> RUN on start; RUN -> DONE after NSLICE slice edges;
//   DONE -> IDLE unconditionally after one cycle.
// - Accept edge E0 (IDLE, start=1): latch a, b, carry<=1, count<=0, diff<=0, flags<=0.
// - RUN edge Ek (k=1..NSLICE): slice k-1 computes bits [2k-1:2k-2] from
//   a_reg, ~b_reg, and the carry register; write the 2 result bits into diff;
//   carry <= slice carry-out. Slice 0 is the LSB pair.
// - At E_NSLICE: borrow <= ~final carry; ovf and zero are computed from the completed diff;
//   state <= DONE. done=1 for the single cycle after E_NSLICE.
// - Latency: start edge to done visible = NSLICE cycles (WIDTH=8: 4 cycles).
// - diff and the flags hold their values from DONE until the next accepted start.
//   They are cleared at the accept edge.
// - start while RUN or DONE: ignored, no queueing. a and b are don't-care outside the accept edge.
// - start held high continuously: a new operation is accepted on each IDLE cycle,
//   so one operation completes every NSLICE+2 cycles.
// - rst mid-RUN or in DONE: operation is abandoned, no done pulse, reset values apply next cycle.
// - Boundaries: B=0 gives diff=A, borrow=0. A=B gives zero=1, borrow=0.
//   0-1 gives all-ones, borrow=1.
// STRUCTURE
// - Shared package cla_pkg:
//   - state enum {S_IDLE, S_RUN, S_DONE}
//   - localparam SLICE_W=2
//   - generate-G/propagate-P helper function
// - One sub-module cla2_slice: combinational 2-bit lookahead slice.
//   - Inputs: x[1:0], y[1:0], cin.
//   - Outputs: s[1:0], cout.
//   - Logic: G/P per bit, c1 = g0|p0&cin, cout = g1|p1&c1.
// - Top level: FSM, slice counter, operand/carry registers, diff register
//   (indexed 2-bit write), flag logic.
// TESTING (WIDTH=8)
// - Reset, then a=0x35, b=0x12, 1-cycle start
//   -> done exactly 4 cycles later; diff=0x23, borrow=0, ovf=0, zero=0.
// - a=0x12, b=0x35 -> diff=0xDD, borrow=1, ovf=0, zero=0.
// - a=0x80, b=0x01 -> diff=0x7F, ovf=1, borrow=0.
//   a=0x7F, b=0xFF -> diff=0x80, ovf=1, borrow=1.
// - a=0x5A, b=0x5A -> diff=0x00, zero=1, borrow=0.
//   a=0x00, b=0x01 -> diff=0xFF, borrow=1.
// - Start 0x35-0x12, then pulse start with a=0xFF, b=0x00 while busy
//   -> ignored, result 0x23. Results hold until next start.
// - Assert rst for 1 cycle at RUN cycle 2 -> no done pulse; all outputs at reset values;
//   the next start completes normally.
// - Random 1000 pairs vs. reference a-b model: check diff, borrow, ovf, zero.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and helpers for the digit-serial CLA subtractor.
package cla_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 2;

  // Returns {generate, propagate} for one bit position.
  function automatic logic [1:0] gen_prop(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

endpackage

// File: rtl/cla_serial_subtractor_if.sv
// Operand/result bundle between the lab datapath and the serial subtractor.
interface cla_serial_subtractor_if #(
  parameter int WIDTH = 8
);
  // Handshake: start is sampled only while ready=1; that edge captures a and b.
  // done pulses for one cycle when diff/borrow/ovf/zero are valid; they then
  // hold until the next accepted start. start while busy or done is dropped.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b,
    input  ready, busy, done, diff, borrow, ovf, zero
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, diff, borrow, ovf, zero
  );
endinterface

// File: rtl/cla2_slice.sv
// Combinational 2-bit carry-lookahead slice shared across all digit positions.
module cla2_slice
  import cla_pkg::*;
(
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);

  logic [1:0] gp0;
  logic [1:0] gp1;
  logic       c1;

  assign gp0  = gen_prop(x[0], y[0]);
  assign gp1  = gen_prop(x[1], y[1]);
  assign c1   = gp0[1] | (gp0[0] & cin);
  assign cout = gp1[1] | (gp1[0] & c1);
  assign s    = {gp1[0] ^ c1, gp0[0] ^ cin};

endmodule

// File: rtl/cla_serial_subtractor.sv
// Digit-serial subtractor D = A - B, two bits per clock via A + ~B + 1 through one CLA slice.
module cla_serial_subtractor
  import cla_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  cla_serial_subtractor_if.slave     bus,
  output state_t                     fsm_state
);

  localparam int NSLICE = WIDTH / 2;
  localparam int CNT_W  = $clog2(NSLICE) + 1;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
  logic             ovf_reg;
  logic             zero_reg;

  logic [1:0]       slice_x;
  logic [1:0]       slice_y;
  logic [1:0]       slice_s;
  logic             slice_cout;
  logic [WIDTH-1:0] diff_new;
  logic             last_slice;

  assign last_slice = (count == CNT_W'(NSLICE - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start) state_next = S_RUN;
      S_RUN:   if (last_slice) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Pick the operand digit addressed by count; the subtrahend is fed inverted.
  always_comb begin
    slice_x = '0;
    slice_y = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (count == CNT_W'(i)) begin
        slice_x = a_reg[i*SLICE_W +: SLICE_W];
        slice_y = ~b_reg[i*SLICE_W +: SLICE_W];
      end
    end
  end

  cla2_slice u_slice (
    .x    (slice_x),
    .y    (slice_y),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    diff_new = diff_reg;
    for (int i = 0; i < NSLICE; i++) begin
      if (count == CNT_W'(i)) diff_new[i*SLICE_W +: SLICE_W] = slice_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      carry      <= 1'b1;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            carry      <= 1'b1;
            count      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            ovf_reg    <= 1'b0;
            zero_reg   <= 1'b0;
          end
        end
        S_RUN: begin
          diff_reg <= diff_new;
          carry    <= slice_cout;
          count    <= count + CNT_W'(1);
          if (last_slice) begin
            // No carry out of A + ~B + 1 means A < B.
            borrow_reg <= ~slice_cout;
            ovf_reg    <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) &
                          (a_reg[WIDTH-1] ^ diff_new[WIDTH-1]);
            zero_reg   <= (diff_new == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready  = (state == S_IDLE);
  assign bus.busy   = (state == S_RUN);
  assign bus.done   = (state == S_DONE);
  assign bus.diff   = diff_reg;
  assign bus.borrow = borrow_reg;
  assign bus.ovf    = ovf_reg;
  assign bus.zero   = zero_reg;
  assign fsm_state  = state;

endmodule
